// File: rtl/instruction_encoder_if.sv
// Host byte stream and instruction FIFO write port of the instruction encoder.
// master = host/FIFO side, slave = encoder.
interface instruction_encoder_if #(parameter int CNT_W = 16);
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             frame_clear;
  logic             fifo_full;
  logic             fifo_write;
  logic [81:0]      fifo_wdata;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output byte_in, byte_valid, frame_clear, fifo_full,
    input  byte_ready, fifo_write, fifo_wdata, busy, words_sent
  );

  modport slave (
    input  byte_in, byte_valid, frame_clear, fifo_full,
    output byte_ready, fifo_write, fifo_wdata, busy, words_sent
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs a byte-serial host command stream into 82-bit instruction words and
// writes them to the instruction FIFO, holding the word stable while it is full.
module instruction_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  instruction_encoder_if.slave bus
);

  typedef enum logic [1:0] {HDR, COORD, FILL, PUSH} state_t;

  state_t           state_q, state_d;
  logic [81:0]      word_q, word_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             accept, push;
  logic [2:0]       pos;
  logic [6:0]       lsb;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    push    = 1'b0;
    pos     = '0;
    lsb     = '0;
    accept  = bus.byte_valid && (state_q != PUSH);
    case (state_q)
      HDR: if (accept) begin
        word_d = '0;
        if (bus.byte_in[0]) begin
          word_d[0]   = 1'b1;
          word_d[4:1] = bus.byte_in[7:4];
          state_d     = PUSH;
        end else begin
          word_d[1]     = bus.byte_in[1];
          word_d[50]    = bus.byte_in[2];
          word_d[51]    = bus.byte_in[3];
          word_d[81:78] = bus.byte_in[7:4];
          cnt_d         = bus.byte_in[1] ? 3'd6 : 3'd4;
          state_d       = COORD;
        end
      end
      COORD: if (accept) begin
        // byte position within the coordinate block, low byte of coord0 first
        pos = (word_q[1] ? 3'd6 : 3'd4) - cnt_q;
        lsb = 7'd2 + {1'b0, pos, 3'b000};
        word_d[lsb +: 8] = bus.byte_in;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          cnt_d   = word_q[51] ? 3'd1 : 3'd3;
          state_d = FILL;
        end
      end
      FILL: if (accept) begin
        if (word_q[51]) begin
          word_d[77:76] = bus.byte_in[1:0];
        end else begin
          pos = 3'd3 - cnt_q;
          lsb = 7'd52 + {1'b0, pos, 3'b000};
          word_d[lsb +: 8] = bus.byte_in;
        end
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = PUSH;
      end
      PUSH: if (!bus.fifo_full) begin
        push    = 1'b1;
        sent_d  = sent_q + 1'b1;
        word_d  = '0;
        state_d = HDR;
      end
      default: state_d = HDR;
    endcase
    // abort wins over any accept or push in the same cycle
    if (bus.frame_clear) begin
      state_d = HDR;
      word_d  = '0;
      cnt_d   = '0;
      sent_d  = sent_q;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= HDR;
      word_q  <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
    end
  end

  assign bus.byte_ready = (state_q != PUSH);
  assign bus.fifo_write = push;
  assign bus.fifo_wdata = word_q;
  assign bus.busy       = (state_q != HDR);
  assign bus.words_sent = sent_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Table vectors, hand-written stall/abort/reset sequences and random frames
// checked against a field-level packing model.
module tb_instruction_encoder;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  instruction_encoder_if #(.CNT_W(CW)) bus();
  instruction_encoder #(.CNT_W(CW)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  typedef struct {
    logic [9:0][7:0] b;
    int              n;
    logic [81:0]     exp;
  } vec_t;

  vec_t        tbl[7];
  int          vectors = 0;
  int          miscompares = 0;
  int          max_gap = 0;
  logic [CW-1:0] exp_words = '0;

  task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    int t;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    t = 0;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready) chk("ready_timeout", 82'(bus.byte_ready), 82'd1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'($urandom);
  endtask

  task automatic run_frame(input logic [9:0][7:0] fb, input int n, input logic [81:0] exp,
                           input string nm);
    for (int i = 0; i < n; i++) send_byte(fb[i]);
    @(negedge clk);
    chk({nm, " write"}, 82'(bus.fifo_write), 82'd1);
    chk({nm, " wdata"}, bus.fifo_wdata, exp);
    exp_words++;
    @(negedge clk);
    chk({nm, " words"}, 82'(bus.words_sent), 82'(exp_words));
    chk({nm, " idle"}, {80'd0, bus.busy, bus.fifo_write}, 82'd0);
    chk({nm, " cleared"}, bus.fifo_wdata, 82'd0);
  endtask

  task automatic rand_frame(output logic [9:0][7:0] fb, output int n, output logic [81:0] exp);
    logic [7:0]  h;
    logic [15:0] cv;
    logic [23:0] col;
    logic [7:0]  tx;
    fb = '0;
    exp = '0;
    h = 8'($urandom);
    fb[0] = h;
    n = 1;
    if (h[0]) begin
      exp = 82'(h[7:4]) * 2 + 82'd1;
    end else begin
      for (int c = 0; c < (h[1] ? 3 : 2); c++) begin
        cv = 16'($urandom);
        fb[n] = cv[7:0];
        fb[n+1] = cv[15:8];
        n += 2;
        exp |= 82'(cv) << (2 + 16 * c);
      end
      if (h[3]) begin
        tx = 8'($urandom);
        fb[n] = tx;
        n++;
        exp |= 82'(tx % 4) << 76;
      end else begin
        col = 24'($urandom);
        fb[n] = col[7:0];
        fb[n+1] = col[15:8];
        fb[n+2] = col[23:16];
        n += 3;
        exp |= 82'(col) << 52;
      end
      exp |= (82'(h[1]) << 1) | (82'(h[2]) << 50) | (82'(h[3]) << 51) | (82'(h[7:4]) << 78);
    end
  endtask

  initial begin
    logic [9:0][7:0] fb;
    int n;
    logic [81:0] exp;

    tbl[0].b = 80'hA1;                   tbl[0].n = 1;  tbl[0].exp = 82'h15;
    tbl[1].b = 80'h3322119ABC56781234F6; tbl[1].n = 10;
    tbl[1].exp = {4'hF, 2'd0, 24'h332211, 1'b0, 1'b1, 16'h9ABC, 16'h5678, 16'h1234, 1'b1, 1'b0};
    tbl[2].b = 80'hFF0002000108;         tbl[2].n = 6;
    tbl[2].exp = {4'h0, 2'd3, 24'h0, 1'b1, 1'b0, 16'h0, 16'h0002, 16'h0001, 1'b0, 1'b0};
    tbl[3].b = 80'h5F;                   tbl[3].n = 1;  tbl[3].exp = 82'hB;
    tbl[4].b = 80'h0F;                   tbl[4].n = 1;  tbl[4].exp = 82'h1;
    tbl[5].b = 80'h030201DDCCBBAA04;     tbl[5].n = 8;
    tbl[5].exp = {4'h0, 2'd0, 24'h030201, 1'b0, 1'b1, 16'h0, 16'hDDCC, 16'hBBAA, 1'b0, 1'b0};
    tbl[6].b = 80'hFE6655443322111A;     tbl[6].n = 8;
    tbl[6].exp = {4'h1, 2'd2, 24'h0, 1'b1, 1'b0, 16'h6655, 16'h4433, 16'h2211, 1'b1, 1'b0};

    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    bus.frame_clear = 1'b0;
    bus.fifo_full = 1'b0;
    #1;
    chk("rst wdata", bus.fifo_wdata, 82'd0);
    chk("rst flags", {79'd0, bus.busy, bus.fifo_write, bus.byte_ready}, 82'd1);
    chk("rst words", 82'(bus.words_sent), 82'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post rst ready", 82'(bus.byte_ready), 82'd1);

    for (int i = 0; i < 7; i++) run_frame(tbl[i].b, tbl[i].n, tbl[i].exp, $sformatf("tbl%0d", i));

    // FIFO full for 5 cycles once the word is complete
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(tbl[1].b[i]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall flags", {79'd0, bus.busy, bus.fifo_write, bus.byte_ready}, 82'd4);
      chk("stall data", bus.fifo_wdata, tbl[1].exp);
    end
    @(negedge clk);
    bus.fifo_full = 1'b0;
    #1;
    chk("stall release write", 82'(bus.fifo_write), 82'd1);
    chk("stall release data", bus.fifo_wdata, tbl[1].exp);
    exp_words++;
    @(negedge clk);
    chk("stall words", 82'(bus.words_sent), 82'(exp_words));
    chk("stall after write", 82'(bus.fifo_write), 82'd0);

    // abort after 3 draw bytes, with a byte presented on the clear cycle
    for (int i = 0; i < 3; i++) send_byte(tbl[1].b[i]);
    @(negedge clk);
    bus.frame_clear = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'h78;
    @(posedge clk);
    #1;
    bus.frame_clear = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk("clear flags", {80'd0, bus.busy, bus.fifo_write}, 82'd0);
    chk("clear wdata", bus.fifo_wdata, 82'd0);
    chk("clear words", 82'(bus.words_sent), 82'(exp_words));
    fb = 80'h31;
    run_frame(fb, 1, 82'h7, "after clear");

    // abort while a push is possible
    bus.fifo_full = 1'b1;
    send_byte(8'hA1);
    @(negedge clk);
    bus.fifo_full = 1'b0;
    bus.frame_clear = 1'b1;
    #1;
    chk("clear push write", 82'(bus.fifo_write), 82'd0);
    @(posedge clk);
    #1;
    bus.frame_clear = 1'b0;
    @(negedge clk);
    chk("clear push busy", 82'(bus.busy), 82'd0);
    chk("clear push words", 82'(bus.words_sent), 82'(exp_words));

    // reset mid-COORD
    send_byte(8'hF6);
    send_byte(8'h34);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("rst coord flags", {79'd0, bus.busy, bus.fifo_write, bus.byte_ready}, 82'd1);
    chk("rst coord wdata", bus.fifo_wdata, 82'd0);
    chk("rst coord words", 82'(bus.words_sent), 82'd0);
    exp_words = '0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst coord quiet", {80'd0, bus.busy, bus.fifo_write}, 82'd0);
    end
    run_frame(tbl[0].b, 1, tbl[0].exp, "after rst");

    // reset during a push stall
    bus.fifo_full = 1'b1;
    send_byte(8'hA1);
    @(negedge clk);
    chk("pre rst stall busy", 82'(bus.busy), 82'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst stall flags", {80'd0, bus.busy, bus.fifo_write}, 82'd0);
    chk("rst stall wdata", bus.fifo_wdata, 82'd0);
    bus.fifo_full = 1'b0;
    exp_words = '0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst stall quiet", 82'(bus.fifo_write), 82'd0);
    end
    chk("rst stall words", 82'(bus.words_sent), 82'd0);

    // random frames with idle gaps; the 4-bit counter wraps several times
    max_gap = 2;
    for (int f = 0; f < 40; f++) begin
      rand_frame(fb, n, exp);
      run_frame(fb, n, exp, $sformatf("rand%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
